// File: rtl/svf_sched.sv
// svf_sched: one state-variable filter datapath and one external 32x16
// multiplier time-shared across NCH channels. Each clkEn tick sweeps the
// channels in order, seven cycles per channel, and presents each channel's
// updated low/band/high for one oValid cycle.
// Optional build macro SVF_SCHED_SAT_EN: clamp the low/high/band updates to
// the signed 32-bit range instead of letting them wrap.
module svf_sched #(
  parameter int NCH  = 2,
  parameter int CH_W = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clkEn,
  input  logic signed [31:0]       iIn,
  input  logic        [15:0]       iCut,
  input  logic        [15:0]       iRes,
  output logic        [CH_W-1:0]   oCh,
  output logic signed [31:0]       mulA,
  output logic        [15:0]       mulB,
  input  logic signed [31:0]       mulOut,
  output logic signed [31:0]       oLP,
  output logic signed [31:0]       oBP,
  output logic signed [31:0]       oHP,
  output logic        [CH_W-1:0]   oOutCh,
  output logic                     oValid,
  output logic                     oBusy,
  output logic                     oOverrun,
  input  logic                     iClrOvr
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 16;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6
  } state_t;

  state_t                    state_q;
  logic        [CH_W-1:0]    ch_q;
  logic        [CH_W-1:0]    out_ch_q;
  logic signed [DATA_W-1:0]  low_q  [NCH];
  logic signed [DATA_W-1:0]  band_q [NCH];
  logic signed [DATA_W-1:0]  high_q [NCH];
  logic signed [DATA_W-1:0]  mul_a_q;
  logic        [COEF_W-1:0]  mul_b_q;
  logic signed [DATA_W-1:0]  lp_q, bp_q, hp_q;
  logic                      vld_q, busy_q, ovr_q;

  logic signed [DATA_W-1:0]  low_cur, band_cur, high_cur;
  logic signed [DATA_W-1:0]  low_d, high_d, band_d;

`ifdef SVF_SCHED_SAT_EN
  function automatic logic signed [33:0] ext34(input logic signed [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat34(input logic signed [33:0] v);
    if (v > 34'sh0_7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (v < 34'sh3_8000_0000) return 32'sh8000_0000;
    return v[DATA_W-1:0];
  endfunction
`endif

  assign low_cur  = low_q[ch_q];
  assign band_cur = band_q[ch_q];
  assign high_cur = high_q[ch_q];

  // Integrator updates for the active channel; low_cur already holds the new low in P3
  always_comb begin
`ifdef SVF_SCHED_SAT_EN
    low_d  = sat34(ext34(low_cur) + ext34(mulOut));
    high_d = sat34(ext34(iIn) - ext34(low_cur) - ext34(mulOut));
    band_d = sat34(ext34(band_cur) + ext34(mulOut));
`else
    low_d  = low_cur + mulOut;
    high_d = iIn - low_cur - mulOut;
    band_d = band_cur + mulOut;
`endif
  end

  // Sweep sequencer, multiplier operand registers, channel state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      out_ch_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      lp_q     <= '0;
      bp_q     <= '0;
      hp_q     <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        low_q[i]  <= '0;
        band_q[i] <= '0;
        high_q[i] <= '0;
      end
    end else begin
      vld_q <= 1'b0;
      // a tick landing mid-sweep is dropped and flagged; setting beats clearing
      if (iClrOvr) ovr_q <= 1'b0;
      if (clkEn && (state_q != S_IDLE)) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (clkEn) begin
            state_q <= S_P0;
            ch_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_P0: begin
          mul_a_q <= band_cur;
          mul_b_q <= iCut;
          state_q <= S_P1;
        end
        S_P1: begin
          mul_a_q <= band_cur;
          mul_b_q <= iRes;
          state_q <= S_P2;
        end
        S_P2: begin
          low_q[ch_q] <= low_d;
          state_q     <= S_P3;
        end
        S_P3: begin
          high_q[ch_q] <= high_d;
          state_q      <= S_P4;
        end
        S_P4: begin
          mul_a_q <= high_cur;
          mul_b_q <= iCut;
          state_q <= S_P5;
        end
        S_P5: begin
          state_q <= S_P6;
        end
        S_P6: begin
          band_q[ch_q] <= band_d;
          lp_q         <= low_cur;
          bp_q         <= band_d;
          hp_q         <= high_cur;
          out_ch_q     <= ch_q;
          vld_q        <= 1'b1;
          if (ch_q == LAST_CH) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_P0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oCh      = ch_q;
  assign mulA     = mul_a_q;
  assign mulB     = mul_b_q;
  assign oLP      = lp_q;
  assign oBP      = bp_q;
  assign oHP      = hp_q;
  assign oOutCh   = out_ch_q;
  assign oValid   = vld_q;
  assign oBusy    = busy_q;
  assign oOverrun = ovr_q;

endmodule

// File: tb/tb_svf_sched.sv
// Testbench for svf_sched: external multiplier model, requester arrays
// indexed by oCh, a sweep-level reference model feeding a scoreboard, and a
// monitor that checks every oValid against the scoreboard.
module tb_svf_sched;

  localparam int NCH  = 2;
  localparam int CH_W = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   clkEn;
  logic                   iClrOvr;
  logic signed [31:0]     iIn;
  logic        [15:0]     iCut, iRes;
  logic        [CH_W-1:0] oCh, oOutCh;
  logic signed [31:0]     mulA;
  logic        [15:0]     mulB;
  logic signed [31:0]     mulOut;
  logic signed [31:0]     oLP, oBP, oHP;
  logic                   oValid, oBusy, oOverrun;

  svf_sched #(.NCH(NCH), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn),
    .iIn(iIn), .iCut(iCut), .iRes(iRes), .oCh(oCh),
    .mulA(mulA), .mulB(mulB), .mulOut(mulOut),
    .oLP(oLP), .oBP(oBP), .oHP(oHP), .oOutCh(oOutCh),
    .oValid(oValid), .oBusy(oBusy), .oOverrun(oOverrun), .iClrOvr(iClrOvr)
  );

  always #5 clk = ~clk;

  // requester: per-channel values selected by oCh
  logic signed [31:0] in_a  [NCH];
  logic        [15:0] cut_a [NCH];
  logic        [15:0] res_a [NCH];
  assign iIn  = in_a[oCh];
  assign iCut = cut_a[oCh];
  assign iRes = res_a[oCh];

  // external multiplier: one register stage, optional forced product
  logic               ovr_en = 1'b0;
  logic signed [31:0] ovr_val = '0;

  function automatic logic signed [31:0] prod(input logic signed [31:0] a, input logic [15:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 16;
    return p[31:0];
  endfunction

  function automatic logic signed [31:0] mp(input logic signed [31:0] a, input logic [15:0] b);
    return ovr_en ? ovr_val : prod(a, b);
  endfunction

  always @(posedge clk) mulOut <= mp(mulA, mulB);

  // reference model
  function automatic logic signed [31:0] fix(input longint v);
`ifdef SVF_SCHED_SAT_EN
    if (v > longint'(32'sh7FFF_FFFF)) return 32'sh7FFF_FFFF;
    if (v < longint'(32'sh8000_0000)) return 32'sh8000_0000;
`endif
    return v[31:0];
  endfunction

  typedef struct {
    logic [CH_W-1:0]    ch;
    logic signed [31:0] lp, bp, hp;
  } exp_t;

  exp_t               sbq[$];
  logic signed [31:0] m_low [NCH];
  logic signed [31:0] m_band[NCH];
  logic signed [31:0] m_high[NCH];

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_low[c] = '0; m_band[c] = '0; m_high[c] = '0;
    end
    sbq.delete();
  endtask

  task automatic model_sweep();
    exp_t e;
    logic signed [31:0] p1, p2, p3;
    for (int c = 0; c < NCH; c++) begin
      p1 = mp(m_band[c], cut_a[c]);
      p2 = mp(m_band[c], res_a[c]);
      m_low[c]  = fix(longint'(m_low[c]) + longint'(p1));
      m_high[c] = fix(longint'(in_a[c]) - longint'(m_low[c]) - longint'(p2));
      p3 = mp(m_high[c], cut_a[c]);
      m_band[c] = fix(longint'(m_band[c]) + longint'(p3));
      e.ch = CH_W'(c);
      e.lp = m_low[c];
      e.bp = m_band[c];
      e.hp = m_high[c];
      sbq.push_back(e);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && oValid === 1'b1) begin
      if (sbq.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_oValid ch=%0d lp=%h bp=%h hp=%h t=%0t", oOutCh, oLP, oBP, oHP, $time);
      end else begin
        e = sbq.pop_front();
        chk("sb_ch", 32'(oOutCh), 32'(e.ch));
        chk("sb_lp", oLP, e.lp);
        chk("sb_bp", oBP, e.bp);
        chk("sb_hp", oHP, e.hp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_oCh"}, 32'(oCh), 32'd0);
    chk({tag, "_mulA"}, mulA, 32'd0);
    chk({tag, "_mulB"}, 32'(mulB), 32'd0);
    chk({tag, "_oLP"}, oLP, 32'd0);
    chk({tag, "_oBP"}, oBP, 32'd0);
    chk({tag, "_oHP"}, oHP, 32'd0);
    chk({tag, "_oOutCh"}, 32'(oOutCh), 32'd0);
    chk({tag, "_oValid"}, 32'(oValid), 32'd0);
    chk({tag, "_oBusy"}, 32'(oBusy), 32'd0);
    chk({tag, "_oOverrun"}, 32'(oOverrun), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_ch(input int c, input logic [31:0] vin, input logic [15:0] vc, input logic [15:0] vr);
    in_a[c] = vin; cut_a[c] = vc; res_a[c] = vr;
  endtask

  task automatic randomize_inputs();
    for (int c = 0; c < NCH; c++) begin
      in_a[c]  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(16'($urandom)) * 16);
      cut_a[c] = 16'($urandom);
      res_a[c] = 16'($urandom);
    end
  endtask

  task automatic tick_accept();
    model_sweep();
    clkEn = 1'b1;
    cyc(1);
    clkEn = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (oBusy === 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    if (oBusy !== 1'b0) begin
      nvec++;
      nmis++;
      $display("FAIL busy_timeout got=%b want=0", oBusy);
    end
    cyc(1);
  endtask

  logic signed [31:0] c0_lp, c0_bp, c0_hp, c1_lp, c1_bp, c1_hp;

  // call right after tick_accept: checks sequencing and captures both channels
  task automatic watch_sweep();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("seq_oCh", 32'(oCh), (k < 7) ? 32'd0 : 32'd1);
      chk("seq_oValid", 32'(oValid), (k == 7 || k == 14) ? 32'd1 : 32'd0);
      chk("seq_oBusy", 32'(oBusy), (k < 14) ? 32'd1 : 32'd0);
      if (k == 7)  begin c0_lp = oLP; c0_bp = oBP; c0_hp = oHP; end
      if (k == 14) begin c1_lp = oLP; c1_bp = oBP; c1_hp = oHP; end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] want_wrap;
    rst = 1'b1; clkEn = 1'b0; iClrOvr = 1'b0;
    for (int c = 0; c < NCH; c++) set_ch(c, 32'd0, 16'd0, 16'd0);
    model_clear();
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk_zero_outputs("reset");

    // single-channel response on ch0, ch1 idle at zero
    set_ch(0, 32'h0001_0000, 16'h8000, 16'h0000);
    set_ch(1, 32'h0, 16'h8000, 16'h0000);
    tick_accept();
    watch_sweep();
    chk("t1_lp", c0_lp, 32'h0);
    chk("t1_bp", c0_bp, 32'h8000);
    chk("t1_hp", c0_hp, 32'h1_0000);
    cyc(2);
    tick_accept();
    watch_sweep();
    chk("t2_lp", c0_lp, 32'h4000);
    chk("t2_bp", c0_bp, 32'hE000);
    chk("t2_hp", c0_hp, 32'hC000);

    // two channels from clean state
    do_reset();
    set_ch(0, 32'h0001_0000, 16'h8000, 16'h4000);
    set_ch(1, 32'h0, 16'h8000, 16'h4000);
    tick_accept();
    watch_sweep();
    chk("two_c0_bp", c0_bp, 32'h8000);
    chk("two_c0_hp", c0_hp, 32'h1_0000);
    chk("two_c1_lp", c1_lp, 32'h0);
    chk("two_c1_bp", c1_bp, 32'h0);
    chk("two_c1_hp", c1_hp, 32'h0);

    // overrun: dropped tick mid-sweep, set wins over clear, no extra sweep
    cyc(1);
    randomize_inputs();
    tick_accept();
    cyc(2);
    clkEn = 1'b1;
    cyc(1);
    clkEn = 1'b0;
    chk("ovr_set", 32'(oOverrun), 32'd1);
    clkEn = 1'b1; iClrOvr = 1'b1;
    cyc(1);
    clkEn = 1'b0; iClrOvr = 1'b0;
    chk("ovr_setwins", 32'(oOverrun), 32'd1);
    wait_idle();
    cyc(3);
    chk("ovr_noextra_busy", 32'(oBusy), 32'd0);
    chk("ovr_sticky", 32'(oOverrun), 32'd1);
    iClrOvr = 1'b1;
    cyc(1);
    iClrOvr = 1'b0;
    chk("ovr_clear", 32'(oOverrun), 32'd0);

    // reset in P4 of ch0, then fresh state
    randomize_inputs();
    tick_accept();
    cyc(4);
    do_reset();
    chk_zero_outputs("midrst");
    set_ch(0, 32'h0001_0000, 16'h8000, 16'h0000);
    set_ch(1, 32'h0, 16'h8000, 16'h0000);
    cyc(1);
    tick_accept();
    watch_sweep();
    chk("rst_lp", c0_lp, 32'h0);
    chk("rst_bp", c0_bp, 32'h8000);
    chk("rst_hp", c0_hp, 32'h1_0000);

    // minimum tick period: accepted right after the sweep returns to idle
    randomize_inputs();
    tick_accept();
    cyc(14);
    randomize_inputs();
    tick_accept();
    chk("b2b_busy", 32'(oBusy), 32'd1);
    wait_idle();
    chk("b2b_no_ovr", 32'(oOverrun), 32'd0);

    // randomized sweeps with random gaps
    for (int n = 0; n < 30; n++) begin
      randomize_inputs();
      tick_accept();
      cyc(14 + int'($urandom_range(0, 4)));
    end
    wait_idle();

    // large forced products: wrap vs clamp of low
    do_reset();
    for (int c = 0; c < NCH; c++) set_ch(c, 32'h0, 16'h0, 16'h0);
    ovr_en = 1'b1;
    ovr_val = 32'sh7FFF_0000;
    cyc(2);
    tick_accept();
    watch_sweep();
    chk("big1_lp", c0_lp, 32'h7FFF_0000);
    tick_accept();
    watch_sweep();
`ifdef SVF_SCHED_SAT_EN
    want_wrap = 32'h7FFF_FFFF;
`else
    want_wrap = 32'hFFFE_0000;
`endif
    chk("big2_lp", c0_lp, want_wrap);
    ovr_en = 1'b0;
    cyc(3);

    nvec++;
    if (sbq.size() != 0) begin
      nmis++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
